// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the instruction/data bus arbiter.
//  - state_t : sequencer states (IDLE, ADDR, DATA)
//  - owner_t : which pipeline port owns the transaction in flight
//  - SEL_W   : byte-lane select width on every port
package mem_bus_arbiter_pkg;

  localparam int SEL_W = 4;
  localparam logic [SEL_W-1:0] SEL_ALL = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// SRAM-style handshake bus between the arbiter (master) and the SoC bus bridge (slave).
//  req/we/sel/addr/wdata : address phase, driven by the master, stable while req
//  addr_ok               : address accepted this cycle
//  data_ok/rdata         : read data or write response this cycle
interface mem_bus_arbiter_if
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              req;
  logic              we;
  logic [SEL_W-1:0]  sel;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, sel, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, we, sel, addr, wdata,
    output addr_ok, data_ok, rdata
  );

endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one handshake bus between the fetch port (inst_*) and the mem-stage port (data_*).
// One transaction in flight at a time; data has fixed priority. Read data is passed through
// from the bus, acks are single-cycle, and stall requests go back to pipeline control.
//  clk, rst      : rising-edge clock, synchronous active-high reset
//  inst_*        : fetch request/address in, ack/rdata/stall out
//  data_*        : load/store request/we/sel/addr/wdata in, ack/rdata/stall out
//  flush_i       : kills the fetch transaction (its ack is suppressed); never affects data
//  bus           : master side of the shared bus
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  output logic              inst_ack_o,
  output logic [DATA_W-1:0] inst_rdata_o,
  output logic              inst_stall_o,
  input  logic              data_ce_i,
  input  logic              data_we_i,
  input  logic [SEL_W-1:0]  data_sel_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  output logic              data_ack_o,
  output logic [DATA_W-1:0] data_rdata_o,
  output logic              data_stall_o,
  input  logic              flush_i,
  mem_bus_arbiter_if.master bus
);

  state_t state, state_nxt;
  owner_t owner, owner_nxt;
  logic   drop, drop_nxt;
  logic   grant;

  logic              lat_we;
  logic [SEL_W-1:0]  lat_sel;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      owner <= OWN_INST;
      drop  <= 1'b0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      drop  <= drop_nxt;
    end
  end

  // NOTE: the request latch has no reset; the bus fields are gated by the ADDR state,
  // so its contents are never visible until a grant has loaded it.
  always_ff @(posedge clk) begin
    if (grant) begin
      if (owner_nxt == OWN_DATA) begin
        lat_we    <= data_we_i;
        lat_sel   <= data_sel_i;
        lat_addr  <= data_addr_i;
        lat_wdata <= data_wdata_i;
      end else begin
        lat_we    <= 1'b0;
        lat_sel   <= SEL_ALL;
        lat_addr  <= inst_addr_i;
        lat_wdata <= '0;
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    drop_nxt  = drop;
    grant     = 1'b0;
    case (state)
      ST_IDLE: begin
        drop_nxt = 1'b0;
        if (data_ce_i) begin
          grant     = 1'b1;
          owner_nxt = OWN_DATA;
          state_nxt = ST_ADDR;
        end else if (inst_req_i && !flush_i) begin
          grant     = 1'b1;
          owner_nxt = OWN_INST;
          state_nxt = ST_ADDR;
        end
      end
      ST_ADDR: begin
        // A flushed fetch still runs to completion on the bus; only its ack is hidden.
        if (flush_i && owner == OWN_INST) drop_nxt = 1'b1;
        if (bus.addr_ok) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (flush_i && owner == OWN_INST) drop_nxt = 1'b1;
        if (bus.data_ok) begin
          state_nxt = ST_IDLE;
          drop_nxt  = 1'b0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  logic in_addr;
  logic done;

  assign in_addr = (state == ST_ADDR);
  assign done    = (state == ST_DATA) && bus.data_ok && !drop;

  assign bus.req   = in_addr;
  assign bus.we    = in_addr && lat_we;
  assign bus.sel   = in_addr ? lat_sel   : '0;
  assign bus.addr  = in_addr ? lat_addr  : '0;
  assign bus.wdata = in_addr ? lat_wdata : '0;

  assign inst_ack_o   = done && (owner == OWN_INST);
  assign data_ack_o   = done && (owner == OWN_DATA);
  assign inst_rdata_o = bus.rdata;
  assign data_rdata_o = bus.rdata;
  assign inst_stall_o = inst_req_i && !inst_ack_o;
  assign data_stall_o = data_ce_i && !data_ack_o;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: a cycle table for the basic transactions,
// scripted multi-cycle corner cases, then a randomized run against a transaction-level model.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack_o;
  logic [31:0] inst_rdata_o;
  logic        inst_stall_o;
  logic        data_ce;
  logic        data_we;
  logic [3:0]  data_sel;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_ack_o;
  logic [31:0] data_rdata_o;
  logic        data_stall_o;
  logic        flush;

  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req_i   (inst_req),
    .inst_addr_i  (inst_addr),
    .inst_ack_o   (inst_ack_o),
    .inst_rdata_o (inst_rdata_o),
    .inst_stall_o (inst_stall_o),
    .data_ce_i    (data_ce),
    .data_we_i    (data_we),
    .data_sel_i   (data_sel),
    .data_addr_i  (data_addr),
    .data_wdata_i (data_wdata),
    .data_ack_o   (data_ack_o),
    .data_rdata_o (data_rdata_o),
    .data_stall_o (data_stall_o),
    .flush_i      (flush),
    .bus          (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    inst_req = 1'b0; inst_addr = '0;
    data_ce = 1'b0; data_we = 1'b0; data_sel = '0; data_addr = '0; data_wdata = '0;
    flush = 1'b0;
    bus_if.addr_ok = 1'b0; bus_if.data_ok = 1'b0; bus_if.rdata = '0;
  endtask

  task automatic check_bus(input string tag, input logic req, input logic we,
                           input logic [3:0] sel, input logic [31:0] addr);
    check({tag, " bus_req"},  32'(bus_if.req),  32'(req));
    check({tag, " bus_we"},   32'(bus_if.we),   32'(we));
    check({tag, " bus_sel"},  32'(bus_if.sel),  32'(sel));
    check({tag, " bus_addr"}, bus_if.addr, addr);
  endtask

  // One table row = one clock cycle: inputs, then expected outputs for that cycle.
  typedef struct {
    logic        rst;
    logic        ireq;
    logic [31:0] iaddr;
    logic        dce;
    logic        dwe;
    logic [3:0]  dsel;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        flush;
    logic        aok;
    logic        dok;
    logic [31:0] rdata;
    logic        e_req;
    logic        e_we;
    logic [3:0]  e_sel;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_iack;
    logic        e_dack;
    logic        e_istall;
    logic        e_dstall;
  } vec_t;

  localparam logic [31:0] Z = 32'h0;
  localparam int NV = 21;
  vec_t tv [NV];
  vec_t zv;

  // Random-phase model state
  bit          open, sl_data_phase, pend_chk, exp_grant;
  bit          e_data, e_we, t_data, t_we, t_flushed;
  logic [3:0]  e_sel, t_sel;
  logic [31:0] e_addr, e_wdata, t_addr, t_wdata;
  bit          i_ack_seen, d_ack_seen, flush_prev;
  bit          open_now, is_new, ending, exp_iack, exp_dack;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    zv = '{1'b0,1'b0,Z,1'b0,1'b0,4'h0,Z,Z,1'b0,1'b0,1'b0,Z, 1'b0,1'b0,4'h0,Z,Z, 1'b0,1'b0,1'b0,1'b0};
    tv[0]  = '{1'b1,1'b0,Z,1'b0,1'b0,4'h0,Z,Z,1'b0,1'b0,1'b0,Z, 1'b0,1'b0,4'h0,Z,Z, 1'b0,1'b0,1'b0,1'b0};
    tv[1]  = zv;
    // load: grant, addr phase, data phase with ack at N+2
    tv[2]  = '{1'b0,1'b0,Z,1'b1,1'b0,4'hF,32'h1000,Z,1'b0,1'b0,1'b0,Z, 1'b0,1'b0,4'h0,Z,Z, 1'b0,1'b0,1'b0,1'b1};
    tv[3]  = '{1'b0,1'b0,Z,1'b1,1'b0,4'hF,32'h1000,Z,1'b0,1'b1,1'b0,Z, 1'b1,1'b0,4'hF,32'h1000,Z, 1'b0,1'b0,1'b0,1'b1};
    tv[4]  = '{1'b0,1'b0,Z,1'b1,1'b0,4'hF,32'h1000,Z,1'b0,1'b0,1'b1,32'hDEADBEEF, 1'b0,1'b0,4'h0,Z,Z, 1'b0,1'b1,1'b0,1'b0};
    tv[5]  = zv;
    // store: ack only on data_ok
    tv[6]  = '{1'b0,1'b0,Z,1'b1,1'b1,4'h3,32'h2000,32'h00AB00AB,1'b0,1'b0,1'b0,Z, 1'b0,1'b0,4'h0,Z,Z, 1'b0,1'b0,1'b0,1'b1};
    tv[7]  = '{1'b0,1'b0,Z,1'b1,1'b1,4'h3,32'h2000,32'h00AB00AB,1'b0,1'b0,1'b0,Z, 1'b1,1'b1,4'h3,32'h2000,32'h00AB00AB, 1'b0,1'b0,1'b0,1'b1};
    tv[8]  = '{1'b0,1'b0,Z,1'b1,1'b1,4'h3,32'h2000,32'h00AB00AB,1'b0,1'b1,1'b0,Z, 1'b1,1'b1,4'h3,32'h2000,32'h00AB00AB, 1'b0,1'b0,1'b0,1'b1};
    tv[9]  = '{1'b0,1'b0,Z,1'b1,1'b1,4'h3,32'h2000,32'h00AB00AB,1'b0,1'b0,1'b0,Z, 1'b0,1'b0,4'h0,Z,Z, 1'b0,1'b0,1'b0,1'b1};
    tv[10] = '{1'b0,1'b0,Z,1'b1,1'b1,4'h3,32'h2000,32'h00AB00AB,1'b0,1'b0,1'b1,Z, 1'b0,1'b0,4'h0,Z,Z, 1'b0,1'b1,1'b0,1'b0};
    tv[11] = zv;
    // conflict: data first, inst bus_req two cycles after data_ack
    tv[12] = '{1'b0,1'b1,32'h400,1'b1,1'b0,4'hF,32'h3000,Z,1'b0,1'b0,1'b0,Z, 1'b0,1'b0,4'h0,Z,Z, 1'b0,1'b0,1'b1,1'b1};
    tv[13] = '{1'b0,1'b1,32'h400,1'b1,1'b0,4'hF,32'h3000,Z,1'b0,1'b1,1'b0,Z, 1'b1,1'b0,4'hF,32'h3000,Z, 1'b0,1'b0,1'b1,1'b1};
    tv[14] = '{1'b0,1'b1,32'h400,1'b1,1'b0,4'hF,32'h3000,Z,1'b0,1'b0,1'b1,32'h11112222, 1'b0,1'b0,4'h0,Z,Z, 1'b0,1'b1,1'b1,1'b0};
    tv[15] = '{1'b0,1'b1,32'h400,1'b0,1'b0,4'h0,Z,Z,1'b0,1'b0,1'b0,Z, 1'b0,1'b0,4'h0,Z,Z, 1'b0,1'b0,1'b1,1'b0};
    tv[16] = '{1'b0,1'b1,32'h400,1'b0,1'b0,4'h0,Z,Z,1'b0,1'b1,1'b0,Z, 1'b1,1'b0,4'hF,32'h400,Z, 1'b0,1'b0,1'b1,1'b0};
    tv[17] = '{1'b0,1'b1,32'h400,1'b0,1'b0,4'h0,Z,Z,1'b0,1'b0,1'b1,32'h33334444, 1'b0,1'b0,4'h0,Z,Z, 1'b1,1'b0,1'b0,1'b0};
    tv[18] = zv;
    // flush together with inst_req in IDLE: no grant
    tv[19] = '{1'b0,1'b1,32'h700,1'b0,1'b0,4'h0,Z,Z,1'b1,1'b0,1'b0,Z, 1'b0,1'b0,4'h0,Z,Z, 1'b0,1'b0,1'b1,1'b0};
    tv[20] = zv;

    clear_inputs();
    rst = 1'b1;
    next_cycle();
    next_cycle();

    for (int i = 0; i < NV; i++) begin
      rst = tv[i].rst; inst_req = tv[i].ireq; inst_addr = tv[i].iaddr;
      data_ce = tv[i].dce; data_we = tv[i].dwe; data_sel = tv[i].dsel;
      data_addr = tv[i].daddr; data_wdata = tv[i].dwdata; flush = tv[i].flush;
      bus_if.addr_ok = tv[i].aok; bus_if.data_ok = tv[i].dok; bus_if.rdata = tv[i].rdata;
      @(negedge clk);
      check($sformatf("v%0d bus_req", i), 32'(bus_if.req), 32'(tv[i].e_req));
      if (tv[i].e_req || tv[i].rst) begin
        check($sformatf("v%0d bus_we", i),   32'(bus_if.we),  32'(tv[i].e_we));
        check($sformatf("v%0d bus_sel", i),  32'(bus_if.sel), 32'(tv[i].e_sel));
        check($sformatf("v%0d bus_addr", i), bus_if.addr, tv[i].e_addr);
      end
      if (tv[i].e_we || tv[i].rst)
        check($sformatf("v%0d bus_wdata", i), bus_if.wdata, tv[i].e_wdata);
      check($sformatf("v%0d inst_ack", i),   32'(inst_ack_o),   32'(tv[i].e_iack));
      check($sformatf("v%0d data_ack", i),   32'(data_ack_o),   32'(tv[i].e_dack));
      check($sformatf("v%0d inst_stall", i), 32'(inst_stall_o), 32'(tv[i].e_istall));
      check($sformatf("v%0d data_stall", i), 32'(data_stall_o), 32'(tv[i].e_dstall));
      if (tv[i].e_iack) check($sformatf("v%0d inst_rdata", i), inst_rdata_o, tv[i].rdata);
      if (tv[i].e_dack) check($sformatf("v%0d data_rdata", i), data_rdata_o, tv[i].rdata);
      next_cycle();
    end
    clear_inputs();
    rst = 1'b0;

    // Stalled bus: store waits 5 cycles for addr_ok while a fetch also waits.
    data_ce = 1'b1; data_we = 1'b1; data_sel = 4'hC; data_addr = 32'h4000; data_wdata = 32'h12345678;
    inst_req = 1'b1; inst_addr = 32'h800;
    @(negedge clk);
    check("stall grant bus_req", 32'(bus_if.req), 32'd0);
    next_cycle();
    for (int k = 0; k < 6; k++) begin
      bus_if.addr_ok = (k == 5);
      @(negedge clk);
      check_bus($sformatf("stall c%0d", k), 1'b1, 1'b1, 4'hC, 32'h4000);
      check($sformatf("stall c%0d bus_wdata", k), bus_if.wdata, 32'h12345678);
      check($sformatf("stall c%0d stalls", k), {30'd0, inst_stall_o, data_stall_o}, 32'd3);
      next_cycle();
    end
    bus_if.addr_ok = 1'b0; bus_if.data_ok = 1'b1; bus_if.rdata = 32'h0;
    @(negedge clk);
    check("stall store ack", {30'd0, inst_ack_o, data_ack_o}, 32'd1);
    next_cycle();
    data_ce = 1'b0; bus_if.data_ok = 1'b0;
    @(negedge clk);
    check("stall idle bus_req", 32'(bus_if.req), 32'd0);
    next_cycle();
    bus_if.addr_ok = 1'b1;
    @(negedge clk);
    check_bus("stall fetch", 1'b1, 1'b0, 4'hF, 32'h800);
    next_cycle();
    bus_if.addr_ok = 1'b0; bus_if.data_ok = 1'b1; bus_if.rdata = 32'hCAFEF00D;
    @(negedge clk);
    check("stall fetch ack", {30'd0, inst_ack_o, data_ack_o}, 32'd2);
    check("stall fetch rdata", inst_rdata_o, 32'hCAFEF00D);
    next_cycle();
    clear_inputs();

    // Flush while the fetch is in DATA: ack suppressed, next fetch served normally.
    inst_req = 1'b1; inst_addr = 32'h500;
    next_cycle();
    bus_if.addr_ok = 1'b1;
    next_cycle();
    bus_if.addr_ok = 1'b0; flush = 1'b1; inst_req = 1'b0;
    next_cycle();
    flush = 1'b0;
    next_cycle();
    next_cycle();
    bus_if.data_ok = 1'b1; bus_if.rdata = 32'hBADBAD00;
    @(negedge clk);
    check("flush suppressed ack", {30'd0, inst_ack_o, data_ack_o}, 32'd0);
    next_cycle();
    bus_if.data_ok = 1'b0; inst_req = 1'b1; inst_addr = 32'h600;
    @(negedge clk);
    check("flush idle bus_req", 32'(bus_if.req), 32'd0);
    next_cycle();
    bus_if.addr_ok = 1'b1;
    @(negedge clk);
    check_bus("flush refetch", 1'b1, 1'b0, 4'hF, 32'h600);
    next_cycle();
    bus_if.addr_ok = 1'b0; bus_if.data_ok = 1'b1; bus_if.rdata = 32'h600D600D;
    @(negedge clk);
    check("flush refetch ack", {30'd0, inst_ack_o, data_ack_o}, 32'd2);
    check("flush refetch rdata", inst_rdata_o, 32'h600D600D);
    next_cycle();
    clear_inputs();

    // Flush never affects a data transaction.
    data_ce = 1'b1; data_addr = 32'h5000; data_sel = 4'hF;
    next_cycle();
    bus_if.addr_ok = 1'b1; flush = 1'b1;
    next_cycle();
    bus_if.addr_ok = 1'b0;
    next_cycle();
    flush = 1'b0; bus_if.data_ok = 1'b1; bus_if.rdata = 32'h0DA7A000;
    @(negedge clk);
    check("flush data ack", {30'd0, inst_ack_o, data_ack_o}, 32'd1);
    check("flush data rdata", data_rdata_o, 32'h0DA7A000);
    next_cycle();
    clear_inputs();

    // Reset during the address phase abandons the transaction.
    data_ce = 1'b1; data_addr = 32'h6000; data_sel = 4'hF;
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("rst addr bus_req", 32'(bus_if.req), 32'd1);
    next_cycle();
    rst = 1'b0; data_ce = 1'b0; bus_if.data_ok = 1'b1; bus_if.rdata = 32'h5151;
    @(negedge clk);
    check("rst after bus_req", 32'(bus_if.req), 32'd0);
    check("rst stray ack", {30'd0, inst_ack_o, data_ack_o}, 32'd0);
    next_cycle();
    clear_inputs();

    // Randomized run against a transaction-level model.
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    open = 0; sl_data_phase = 0; pend_chk = 0;
    i_ack_seen = 0; d_ack_seen = 0; flush_prev = 0;
    t_data = 0; t_flushed = 0; t_we = 0; t_sel = '0; t_addr = '0; t_wdata = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (d_ack_seen) data_ce = 1'b0;
      if (!data_ce && $urandom_range(3) == 0) begin
        data_ce    = 1'b1;
        data_we    = 1'($urandom_range(1));
        data_sel   = 4'($urandom_range(15));
        data_addr  = 32'h8000_0000 | ($urandom() & 32'h0FFF_FFFC);
        data_wdata = $urandom();
      end
      if (i_ack_seen || flush_prev) inst_req = 1'b0;
      if (!inst_req && $urandom_range(2) == 0) begin
        inst_req  = 1'b1;
        inst_addr = $urandom() & 32'h0000_FFFC;
      end
      flush = ($urandom_range(11) == 0);
      bus_if.addr_ok = 1'b0; bus_if.data_ok = 1'b0; bus_if.rdata = $urandom();
      if (sl_data_phase) bus_if.data_ok = ($urandom_range(2) == 0);
      else if (bus_if.req) bus_if.addr_ok = 1'($urandom_range(1));
      @(negedge clk);

      open_now = open | bus_if.req;
      is_new   = bus_if.req & ~open;
      if (pend_chk) begin
        check("rnd grant", 32'(bus_if.req), 32'(exp_grant));
        pend_chk = 0;
      end
      if (is_new) begin
        t_data = e_data; t_we = e_we; t_sel = e_sel; t_addr = e_addr; t_wdata = e_wdata;
        t_flushed = 0;
      end
      if (bus_if.req) begin
        check_bus("rnd", 1'b1, t_we, t_sel, t_addr);
        if (t_we) check("rnd bus_wdata", bus_if.wdata, t_wdata);
      end
      ending   = open_now & bus_if.data_ok;
      exp_dack = ending & t_data;
      exp_iack = ending & ~t_data & ~t_flushed;
      check("rnd acks", {30'd0, inst_ack_o, data_ack_o}, {30'd0, exp_iack, exp_dack});
      check("rnd stalls", {30'd0, inst_stall_o, data_stall_o},
            {30'd0, inst_req & ~exp_iack, data_ce & ~exp_dack});
      if (exp_dack) check("rnd data_rdata", data_rdata_o, bus_if.rdata);
      if (exp_iack) check("rnd inst_rdata", inst_rdata_o, bus_if.rdata);
      if (open_now && !ending && flush && !t_data) t_flushed = 1;
      if (!open_now) begin
        // Bus free this cycle: next cycle must start the highest-priority live request.
        pend_chk  = 1;
        exp_grant = data_ce | (inst_req & ~flush);
        e_data    = data_ce;
        e_we      = data_ce & data_we;
        e_sel     = data_ce ? data_sel : 4'hF;
        e_addr    = data_ce ? data_addr : inst_addr;
        e_wdata   = data_wdata;
      end
      if (bus_if.req && bus_if.addr_ok) sl_data_phase = 1;
      if (ending) sl_data_phase = 0;
      open = open_now & ~ending;
      i_ack_seen = inst_ack_o;
      d_ack_seen = data_ack_o;
      flush_prev = flush;
      next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
